dm_responder: RTL and testbench

//  Data-memory responder: the slave end of the memory-stage load/store interface.

---
 rtl/dm_responder_pkg.sv | 37 +++
 rtl/dm_responder_if.sv | 41 ++++
 rtl/dm_lane_align.sv | 57 +++++
 rtl/dm_responder.sv | 174 +++++++++++++++++
 tb/tb_dm_responder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg
//   Shared definitions for the data-memory responder.
//   - DMOP_* access-size/extension codes carried on req_dmop
//   - FSM state type used by dm_responder
//   - dm_misaligned(): alignment rule for an access size
package dm_responder_pkg;

    // Access size / extension codes
    localparam logic [2:0] DMOP_W  = 3'd0;   // word
    localparam logic [2:0] DMOP_H  = 3'd1;   // half, sign-extended
    localparam logic [2:0] DMOP_HU = 3'd2;   // half, zero-extended
    localparam logic [2:0] DMOP_B  = 3'd3;   // byte, sign-extended
    localparam logic [2:0] DMOP_BU = 3'd4;   // byte, zero-extended

    // Wait-counter width; WAIT_CYCLES must fit in it
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

    // Unknown DMOP codes are treated as word accesses, so they follow the
    // word alignment rule here and the word lane path in dm_lane_align.
    function automatic logic dm_misaligned(input logic [2:0] dmop,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (dmop)
            DMOP_H, DMOP_HU: bad = addr_lo[0];
            DMOP_B, DMOP_BU: bad = 1'b0;
            default:         bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if
//   Load/store request/response bundle between the memory stage (master)
//   and the data-memory responder (slave).
//   Request : req_valid, req_ready, req_wr, req_dmop, req_addr, req_wd, req_pc
//   Response: rsp_valid, rsp_ready, rsp_rd, rsp_err
//   Status  : busy (responder not idle, for the stall unit)
//   Log     : log_valid pulses for one cycle when a store commits, with the
//             issuing PC, word-aligned address and merged word written.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_dmop;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic [31:0] req_pc;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_err;

    logic        busy;

    logic        log_valid;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_data;

    modport master (
        output req_valid, req_wr, req_dmop, req_addr, req_wd, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd, rsp_err, busy,
        input  log_valid, log_pc, log_addr, log_data
    );

    modport slave (
        input  req_valid, req_wr, req_dmop, req_addr, req_wd, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rd, rsp_err, busy,
        output log_valid, log_pc, log_addr, log_data
    );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align
//   Combinational byte-lane handling for one 32-bit memory word.
//   Ports:
//     dmop      in  3   access size/extension (DMOP_*)
//     addr_lo   in  2   byte offset within the word
//     wd        in  32  store data, right-aligned
//     old_word  in  32  current contents of the addressed word
//     merged    out 32  old_word with the store lanes replaced
//     load_data out 32  selected lane, sign/zero-extended
module dm_lane_align
    import dm_responder_pkg::*;
(
    input  logic [2:0]  dmop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [3:0]  be;
    logic [31:0] wd_lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b1111;
        wd_lane   = wd;
        load_data = old_word;
        byte_sel  = old_word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        case (dmop)
            DMOP_H, DMOP_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd_lane   = {2{wd[15:0]}};
                load_data = (dmop == DMOP_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
            end
            DMOP_B, DMOP_BU: begin
                be        = 4'b0001 << addr_lo;
                wd_lane   = {4{wd[7:0]}};
                load_data = (dmop == DMOP_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h000000, byte_sel};
            end
            default: ;
        endcase

        // Store data is replicated into every lane, so the byte enables
        // alone decide which lanes of the old word get replaced.
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wd_lane[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder
//   Slave end of the memory-stage load/store interface with a programmable
//   wait latency, standing in for a slow data memory.
//   Parameters:
//     DEPTH_WORDS  words of storage (word index = addr[AW+1:2])
//     WAIT_CYCLES  extra wait cycles before the access commits (0..15)
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     dm     slave modport of dm_responder_if (request, response, busy, store log)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | ready for a request; req_ready=1
//   WAIT    | request latched, down-counter running; commits at count 0
//   RESP    | rsp_valid=1, data/err held until rsp_ready
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    dm_responder_if.slave dm
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > (2**CNT_W - 1)) begin : g_wait_range
        $error("dm_responder: WAIT_CYCLES out of range 0..15");
    end

    dm_state_t    state;
    logic [CNT_W-1:0] cnt;

    logic         wr_q;
    logic [2:0]   dmop_q;
    logic [31:0]  addr_q;
    logic [31:0]  wd_q;
    logic [31:0]  pc_q;

    logic         req_ready_q;
    logic         rsp_valid_q;
    logic [31:0]  rsp_rd_q;
    logic         rsp_err_q;
    logic         busy_q;

    logic         log_valid_q;
    logic [31:0]  log_pc_q;
    logic [31:0]  log_addr_q;
    logic [31:0]  log_data_q;

    logic [31:0]  mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic [31:0]   load_data;
    logic          req_bad;
    logic          commit;

    assign idx      = addr_q[AW+1:2];
    assign old_word = mem[idx];

    // Checked on the live request so an accept can go straight to RESP.
    assign req_bad = dm_misaligned(dm.req_dmop, dm.req_addr[1:0])
                  || ({2'b00, dm.req_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign commit = (state == ST_WAIT) && (cnt == '0);

    dm_lane_align u_lane_align (
        .dmop      (dmop_q),
        .addr_lo   (addr_q[1:0]),
        .wd        (wd_q),
        .old_word  (old_word),
        .merged    (merged),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            dmop_q      <= DMOP_W;
            addr_q      <= '0;
            wd_q        <= '0;
            pc_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            log_valid_q <= 1'b0;
            log_pc_q    <= '0;
            log_addr_q  <= '0;
            log_data_q  <= '0;
        end else begin
            log_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dm.req_valid) begin
                        wr_q        <= dm.req_wr;
                        dmop_q      <= dm.req_dmop;
                        addr_q      <= dm.req_addr;
                        wd_q        <= dm.req_wd;
                        pc_q        <= dm.req_pc;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_bad) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rd_q    <= '0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rd_q    <= wr_q ? 32'h0 : load_data;
                        if (wr_q) begin
                            log_valid_q <= 1'b1;
                            log_pc_q    <= pc_q;
                            log_addr_q  <= {addr_q[31:2], 2'b00};
                            log_data_q  <= merged;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dm.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rd_q    <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset. A reset before the commit edge forces the FSM
    // out of WAIT, so an uncommitted store never reaches the array.
    always_ff @(posedge clk) begin
        if (commit && wr_q) mem[idx] <= merged;
    end

    assign dm.req_ready = req_ready_q;
    assign dm.rsp_valid = rsp_valid_q;
    assign dm.rsp_rd    = rsp_rd_q;
    assign dm.rsp_err   = rsp_err_q;
    assign dm.busy      = busy_q;
    assign dm.log_valid = log_valid_q;
    assign dm.log_pc    = log_pc_q;
    assign dm.log_addr  = log_addr_q;
    assign dm.log_data  = log_data_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int WAIT  = 2;
    localparam int DEPTH = 3072;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if m ();

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dm    (m)
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: word index -> contents, absent means zero
    logic [31:0] model_mem [int unsigned];

    // Results of the last do_req
    logic [31:0] r_rd;
    logic        r_err;
    int          r_lat;
    logic        r_log_valid;
    logic [31:0] r_log_pc, r_log_addr, r_log_data;

    task automatic drive_idle();
        m.req_valid = 1'b0;
        m.req_wr    = 1'b0;
        m.req_dmop  = DMOP_W;
        m.req_addr  = '0;
        m.req_wd    = '0;
        m.req_pc    = '0;
        m.rsp_ready = 1'b0;
    endtask

    // Issue one request, wait for its response, capture it, then retire it.
    // r_lat = posedges after the accept edge until rsp_valid (100 = timeout).
    task automatic do_req(input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] pc);
        int n;
        @(negedge clk);
        m.req_valid = 1'b1;
        m.req_wr    = wr;
        m.req_dmop  = op;
        m.req_addr  = addr;
        m.req_wd    = wd;
        m.req_pc    = pc;
        n = 0;
        while (m.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        r_lat = 0;
        while (m.rsp_valid !== 1'b1 && r_lat < 100) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_rd        = m.rsp_rd;
        r_err       = m.rsp_err;
        r_log_valid = m.log_valid;
        r_log_pc    = m.log_pc;
        r_log_addr  = m.log_addr;
        r_log_data  = m.log_data;
        @(negedge clk);
        m.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        m.rsp_ready = 1'b0;
    endtask

    // Behavioural reference: size/alignment/range rules and lane arithmetic.
    function automatic void model_exec(input logic wr, input logic [2:0] op,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
        int unsigned word;
        int unsigned size;
        int unsigned sh;
        logic [31:0] w, mask, val;
        word = addr >> 2;
        size = (op == DMOP_H || op == DMOP_HU) ? 2 : (op == DMOP_B || op == DMOP_BU) ? 1 : 4;
        sh   = 8 * (addr % 4);
        rd   = 32'h0;
        err  = ((addr % size) != 0) || (word >= DEPTH);
        if (err) return;
        w    = model_mem.exists(word) ? model_mem[word] : 32'h0;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        if (wr) begin
            model_mem[word] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            val = (w >> sh) & mask;
            if ((op == DMOP_H || op == DMOP_B) && val[8*size-1]) val = val | ~mask;
            rd = val;
        end
    endfunction

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", m.req_ready); end
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", m.rsp_valid); end
        total++; if (m.rsp_rd !== 32'h0) begin bad++; $display("FAIL reset_rsp_rd got=%h exp=0", m.rsp_rd); end
        total++; if (m.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", m.rsp_err); end
        total++; if (m.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", m.busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        do_req(1'b1, DMOP_W, 32'h10, 32'h89AB_CDEF, 32'h0000_0400);
        total++; if (r_lat !== WAIT + 1) begin bad++; $display("FAIL sw_latency got=%0d exp=%0d", r_lat, WAIT + 1); end
        total++; if (r_err !== 1'b0) begin bad++; $display("FAIL sw_err got=%b exp=0", r_err); end
        total++; if (r_rd !== 32'h0) begin bad++; $display("FAIL sw_rd got=%h exp=0", r_rd); end
        total++; if (r_log_valid !== 1'b1 || r_log_addr !== 32'h10 || r_log_data !== 32'h89AB_CDEF || r_log_pc !== 32'h400)
            begin bad++; $display("FAIL sw_log got=%b %h %h %h exp=1 00000010 89abcdef 00000400", r_log_valid, r_log_addr, r_log_data, r_log_pc); end
        do_req(1'b0, DMOP_W, 32'h10, 32'h0, 32'h0000_0404);
        total++; if (r_lat !== WAIT + 1) begin bad++; $display("FAIL lw_latency got=%0d exp=%0d", r_lat, WAIT + 1); end
        total++; if (r_rd !== 32'h89AB_CDEF) begin bad++; $display("FAIL lw_rd got=%h exp=89abcdef", r_rd); end
        total++; if (r_log_valid !== 1'b0) begin bad++; $display("FAIL lw_no_log got=%b exp=0", r_log_valid); end
    endtask

    task automatic test_extend();
        do_req(1'b0, DMOP_B, 32'h13, 32'h0, 32'h0);
        total++; if (r_rd !== 32'hFFFF_FF89) begin bad++; $display("FAIL lb_13 got=%h exp=ffffff89", r_rd); end
        do_req(1'b0, DMOP_BU, 32'h13, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h0000_0089) begin bad++; $display("FAIL lbu_13 got=%h exp=00000089", r_rd); end
        do_req(1'b0, DMOP_H, 32'h10, 32'h0, 32'h0);
        total++; if (r_rd !== 32'hFFFF_CDEF) begin bad++; $display("FAIL lh_10 got=%h exp=ffffcdef", r_rd); end
        do_req(1'b0, DMOP_HU, 32'h12, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h0000_89AB) begin bad++; $display("FAIL lhu_12 got=%h exp=000089ab", r_rd); end
    endtask

    task automatic test_partial_store();
        do_req(1'b1, DMOP_B, 32'h11, 32'h0000_0055, 32'h0);
        do_req(1'b1, DMOP_H, 32'h12, 32'h0000_1234, 32'h0);
        do_req(1'b0, DMOP_W, 32'h10, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h1234_55EF) begin bad++; $display("FAIL sb_sh_merge got=%h exp=123455ef", r_rd); end
    endtask

    task automatic test_errors();
        do_req(1'b0, DMOP_W, 32'h12, 32'h0, 32'h0);
        total++; if (r_err !== 1'b1 || r_rd !== 32'h0) begin bad++; $display("FAIL lw_misaligned got=%b/%h exp=1/0", r_err, r_rd); end
        total++; if (r_lat !== 0) begin bad++; $display("FAIL err_latency got=%0d exp=0", r_lat); end
        do_req(1'b1, DMOP_H, 32'h11, 32'h0000_FFFF, 32'h0);
        total++; if (r_err !== 1'b1 || r_rd !== 32'h0) begin bad++; $display("FAIL sh_misaligned got=%b/%h exp=1/0", r_err, r_rd); end
        total++; if (r_log_valid !== 1'b0) begin bad++; $display("FAIL sh_misaligned_log got=%b exp=0", r_log_valid); end
        do_req(1'b0, DMOP_W, 32'h3000, 32'h0, 32'h0);
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL lw_out_of_range got=%b exp=1", r_err); end
        do_req(1'b0, DMOP_W, 32'h2FFC, 32'h0, 32'h0);
        total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lw_last_word got=%b exp=0", r_err); end
        do_req(1'b0, DMOP_W, 32'h10, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h1234_55EF) begin bad++; $display("FAIL err_no_effect got=%h exp=123455ef", r_rd); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        m.req_valid = 1'b1;
        m.req_wr    = 1'b0;
        m.req_dmop  = DMOP_W;
        m.req_addr  = 32'h10;
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        n = 0;
        while (m.rsp_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n !== WAIT + 1) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", n, WAIT + 1); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            // Alternate a store request that must not be taken while busy
            m.req_valid = (i % 2 == 0);
            m.req_wr    = 1'b1;
            m.req_dmop  = DMOP_W;
            m.req_addr  = 32'h10;
            m.req_wd    = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            total++; if (m.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", i, m.rsp_valid); end
            total++; if (m.rsp_rd !== 32'h1234_55EF) begin bad++; $display("FAIL bp_rd_hold cyc=%0d got=%h exp=123455ef", i, m.rsp_rd); end
            total++; if (m.req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, m.req_ready); end
        end
        @(negedge clk);
        m.req_valid = 1'b0;
        m.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        m.rsp_ready = 1'b0;
        total++; if (m.rsp_valid !== 1'b0 || m.busy !== 1'b0 || m.req_ready !== 1'b1)
            begin bad++; $display("FAIL bp_retire got=%b%b%b exp=001", m.rsp_valid, m.busy, m.req_ready); end
        do_req(1'b0, DMOP_W, 32'h10, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h1234_55EF) begin bad++; $display("FAIL bp_ignored_store got=%h exp=123455ef", r_rd); end
    endtask

    task automatic test_reset_mid_op();
        do_req(1'b1, DMOP_W, 32'h20, 32'h0, 32'h0);
        @(negedge clk);
        m.req_valid = 1'b1;
        m.req_wr    = 1'b1;
        m.req_dmop  = DMOP_W;
        m.req_addr  = 32'h20;
        m.req_wd    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        total++; if (m.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_accepted got=%b exp=1", m.busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (m.req_ready !== 1'b1 || m.busy !== 1'b0 || m.rsp_valid !== 1'b0)
            begin bad++; $display("FAIL rst_mid_outputs got=%b%b%b exp=100", m.req_ready, m.busy, m.rsp_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, DMOP_W, 32'h20, 32'h0, 32'h0);
        total++; if (r_rd !== 32'h0 || r_err !== 1'b0) begin bad++; $display("FAIL rst_mid_no_commit got=%h/%b exp=0/0", r_rd, r_err); end
    endtask

    task automatic test_random();
        int unsigned words [$];
        logic [31:0] exp_rd, addr, wd;
        logic        exp_err, wr;
        logic [2:0]  op;
        int unsigned word;
        for (int i = 0; i < 8; i++) words.push_back(i);
        for (int i = DEPTH - 4; i < DEPTH; i++) words.push_back(i);
        foreach (words[k]) begin
            wd = $urandom;
            model_exec(1'b1, DMOP_W, words[k] * 4, wd, exp_rd, exp_err);
            do_req(1'b1, DMOP_W, words[k] * 4, wd, 32'h1000 + k * 4);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) word = DEPTH + $urandom_range(0, 200000);
            else word = words[$urandom_range(0, words.size() - 1)];
            addr = (word * 4) + $urandom_range(0, 3);
            op   = 3'($urandom_range(0, 4));
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            model_exec(wr, op, addr, wd, exp_rd, exp_err);
            do_req(wr, op, addr, wd, 32'h2000 + i * 4);
            total++; if (r_err !== exp_err || r_rd !== exp_rd)
                begin bad++; $display("FAIL rand_%0d wr=%b op=%0d addr=%h got=%b/%h exp=%b/%h", i, wr, op, addr, r_err, r_rd, exp_err, exp_rd); end
            total++; if (r_lat !== (exp_err ? 0 : WAIT + 1))
                begin bad++; $display("FAIL rand_lat_%0d got=%0d exp=%0d", i, r_lat, exp_err ? 0 : WAIT + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
